// File: rtl/if_id_pipe_ctrl.sv
// PC / IF-ID / ID-EX register owner on the responder side of the load-use stall handshake.
// Applies hold, bubble and squash actions and keeps saturating stall/bubble/flush statistics.
module if_id_pipe_ctrl #(
  parameter int               WIDTH    = 32,
  parameter int               CTRL_W   = 9,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int               CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_write,
  input  logic              awrite,
  input  logic              control,
  input  logic              flush,
  input  logic [WIDTH-1:0]  pc_target,
  input  logic [31:0]       instr_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  output logic [WIDTH-1:0]  pc,
  output logic [31:0]       if_id_instr,
  output logic [WIDTH-1:0]  if_id_pc4,
  output logic              if_id_valid,
  output logic [CTRL_W-1:0] id_ex_ctrl,
  output logic              id_ex_valid,
  output logic              stalled,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic              proto_err
);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0]  pc_p0;
  logic [WIDTH-1:0]  pc_plus4;
  logic [31:0]       instr_p1;
  logic [WIDTH-1:0]  pc4_p1;
  logic              vld_p1;
  logic [CTRL_W-1:0] ctrl_p2;
  logic              vld_p2;
  logic              handshake_ok;
  logic              proto_err_q;
  logic [CNT_W-1:0]  stall_q;
  logic [CNT_W-1:0]  bubble_q;
  logic [CNT_W-1:0]  flush_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign pc_plus4     = pc_p0 + WIDTH'(4);
  assign handshake_ok = (pc_write == awrite) && (awrite == control);

  // Stage 0: fetch address; a redirect overrides a PC hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_p0 <= RESET_PC;
    end else if (flush) begin
      pc_p0 <= pc_target;
    end else if (pc_write) begin
      pc_p0 <= pc_plus4;
    end
  end

  // Stage 1: IF/ID register; squash turns the slot into a NOP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_p1 <= '0;
      pc4_p1   <= '0;
      vld_p1   <= 1'b0;
    end else if (flush) begin
      instr_p1 <= '0;
      pc4_p1   <= '0;
      vld_p1   <= 1'b0;
    end else if (awrite) begin
      instr_p1 <= instr_in;
      pc4_p1   <= pc_plus4;
      vld_p1   <= 1'b1;
    end
  end

  // Stage 2: ID/EX control word; flush leaves this stage alone
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_p2 <= '0;
      vld_p2  <= 1'b0;
    end else if (control && vld_p1) begin
      ctrl_p2 <= ctrl_in;
      vld_p2  <= 1'b1;
    end else begin
      ctrl_p2 <= '0;
      vld_p2  <= 1'b0;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      FILL:    if (awrite || flush) state_next = RUN;
      RUN:     if (!pc_write && !awrite && !flush) state_next = STALL;
      STALL:   if (pc_write || flush) state_next = RUN;
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FILL;
      stall_q     <= '0;
      bubble_q    <= '0;
      flush_q     <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state <= state_next;
      if (state == STALL) stall_q <= sat_inc(stall_q);
      if (!control && vld_p1) bubble_q <= sat_inc(bubble_q);
      if (flush) flush_q <= sat_inc(flush_q);
      // A redirect makes any stall request moot, so mismatches only count without flush
      if (!flush && !handshake_ok) proto_err_q <= 1'b1;
    end
  end

  assign pc          = pc_p0;
  assign if_id_instr = instr_p1;
  assign if_id_pc4   = pc4_p1;
  assign if_id_valid = vld_p1;
  assign id_ex_ctrl  = ctrl_p2;
  assign id_ex_valid = vld_p2;
  assign stalled     = (state == STALL);
  assign stall_cnt   = stall_q;
  assign bubble_cnt  = bubble_q;
  assign flush_cnt   = flush_q;
  assign proto_err   = proto_err_q;

endmodule

// File: doc/if_id_pipe_ctrl.md
Name: if_id_pipe_ctrl

Overview:
Responder side of the load-use stall interface. Consumes the hazard unit's pc_write / awrite / control (1 = proceed, 0 = stall/bubble) plus branch/jump flush, and owns the PC register, the IF/ID pipeline register and the ID/EX control-word register. Sits between instruction memory / decode and the EX stage. Applies hold, bubble and squash actions, tracks stall/bubble/flush statistics and flags illegal handshake combinations.

Parameters:
WIDTH, 32, PC and address width
CTRL_W, 9, width of the decoded control word
RESET_PC, 0, PC value after reset
CNT_W, 16, statistics counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
pc_write  in  1  1 = PC may advance, 0 = hold PC
awrite  in  1  1 = load IF/ID, 0 = hold IF/ID
control  in  1  1 = pass ctrl_in to ID/EX, 0 = insert bubble
flush  in  1  taken branch/jump resolved in ID; squash IF/ID
pc_target  in  WIDTH  redirect address, valid when flush=1
instr_in  in  32  instruction fetched at pc
ctrl_in  in  CTRL_W  decoded control word of the IF/ID instruction
pc  out  WIDTH  current fetch address
if_id_instr  out  32  IF/ID instruction
if_id_pc4  out  WIDTH  IF/ID pc+4
if_id_valid  out  1  IF/ID holds a real instruction
id_ex_ctrl  out  CTRL_W  ID/EX control word
id_ex_valid  out  1  ID/EX holds a real instruction
stalled  out  1  FSM in STALL
stall_cnt  out  CNT_W  cycles in STALL
bubble_cnt  out  CNT_W  bubbles inserted while if_id_valid=1
flush_cnt  out  CNT_W  flushes taken
proto_err  out  1  sticky illegal-handshake flag

Behaviour:
- Reset (async, rst=1): pc=RESET_PC; if_id_instr=0, if_id_pc4=0, if_id_valid=0; id_ex_ctrl=0, id_ex_valid=0; all counters 0; proto_err=0; FSM=FILL; stalled=0. Reset mid-operation discards all pipeline contents immediately.
- PC update, priority order: flush -> pc_target (overrides pc_write=0); else pc_write -> pc+4 (mod 2^WIDTH, wraps silently); else hold.
- IF/ID update, priority order: flush -> instr=0 (NOP), pc4=0, valid=0; else awrite -> instr_in, pc+4, valid=1; else hold all fields.
- ID/EX update (flush has no effect here): control=0 or if_id_valid=0 -> ctrl=0, valid=0 (bubble); else ctrl_in, valid=1.
- Latency: instruction at pc appears in IF/ID 1 cycle later; its control word appears in ID/EX 1 cycle after that.
- Legal handshake: pc_write=awrite=control, all 1 or all 0. With flush=0, any mismatch sets proto_err on that edge (sticky until reset). The register actions above still apply per signal. With flush=1, a stall takes no effect and proto_err is not set.
- FSM:
  - FILL: after reset. Next state RUN on the first edge with awrite=1 or flush=1; otherwise stay.
  - RUN: next state STALL on an edge with pc_write=0, awrite=0, flush=0.
  - STALL: stalled=1. Next state RUN when pc_write=1 or flush=1.
- Counters (saturate at all-ones, no wrap):
  - stall_cnt +1 per edge taken while the FSM is in STALL.
  - bubble_cnt +1 when control=0 and if_id_valid=1.
  - flush_cnt +1 when flush=1.
- Simultaneous flush and stall: flush wins; PC redirects, IF/ID squashes, the FSM leaves or avoids STALL, and the ID/EX bubble still follows control.

Test Plan:
- Reset with RESET_PC=0x100, then 3 cycles all-1 handshake -> pc 0x100→0x104→0x108→0x10C; if_id_pc4=0x104 after edge 1; id_ex_valid=1 from edge 2.
- Load-use: one cycle of pc_write=awrite=control=0 mid-stream -> pc and IF/ID held, id_ex_ctrl=0, id_ex_valid=0, stalled=1 for one cycle, stall_cnt=1, bubble_cnt=1.
- flush=1 with pc_target=0x200 while pc_write=0 -> next pc=0x200, if_id_valid=0, if_id_instr=0, flush_cnt=1, proto_err=0, FSM not in STALL.
- pc_write=1, awrite=0, control=1, flush=0 -> proto_err=1 and stays 1; PC advances and IF/ID holds.
- Preload stall_cnt near all-ones (CNT_W=4), then hold the stall for 20 cycles -> stall_cnt saturates at 15.
- Assert rst mid-stall -> outputs return to reset values asynchronously, before the next clock edge; FSM=FILL.
